// File: rtl/minitb_ahb_pipelined_master.sv
// rtl/minitb_ahb_pipelined_master.sv - pipelined AHB-Lite master with command FIFO and in-order responses
//
// Ports:
//   hclk, hreset        clock (rising edge) and asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake; cmd_write, cmd_addr, cmd_size, cmd_wdata describe the transfer
//   rsp_valid           one-cycle completion pulse with rsp_write, rsp_err, rsp_rdata
//   htrans, haddr, hwrite, hsize, hwdata   AHB-Lite address/data phase outputs
//   hrdata, hready, hresp                  AHB-Lite slave response inputs
//
// Commands go through a FIFO, then into the address-phase register (AP), then into
// the data-phase register (DP). AP and DP overlap so a zero-wait slave sees one
// NONSEQ per cycle.
module minitb_ahb_pipelined_master #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32,
  parameter int cmdDepth  = 4
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [2:0]           cmd_size,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic                 rsp_err,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic [1:0]           htrans,
  output logic [addrWidth-1:0] haddr,
  output logic                 hwrite,
  output logic [2:0]           hsize,
  output logic [dataWidth-1:0] hwdata,
  input  logic [dataWidth-1:0] hrdata,
  input  logic                 hready,
  input  logic                 hresp
);

  localparam int PTR_W = $clog2(cmdDepth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Command FIFO storage (no reset needed: validity is tracked by the pointers)
  logic                 fifo_write [cmdDepth];
  logic [addrWidth-1:0] fifo_addr  [cmdDepth];
  logic [2:0]           fifo_size  [cmdDepth];
  logic [dataWidth-1:0] fifo_wdata [cmdDepth];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Address-phase register
  logic                 ap_valid;
  logic                 ap_write;
  logic [addrWidth-1:0] ap_addr;
  logic [2:0]           ap_size;
  logic [dataWidth-1:0] ap_wdata;

  // Data-phase register; the write data itself lives in the hwdata register
  logic dp_valid;
  logic dp_write;

  // Set between the first and second cycle of an ERROR response: the bus
  // shows IDLE and the retained AP entry is not handed to the data phase.
  logic err_hold;

  logic [1:0]           htrans_q;
  logic [dataWidth-1:0] hwdata_q;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic err_first;
  logic ap_accept;
  logic ap_valid_n;
  logic err_hold_n;

  assign cmd_ready     = (count < CNT_W'(cmdDepth));
  assign push          = cmd_valid && cmd_ready;
  assign fifo_nonempty = (count != '0);

  // First ERROR cycle: slave stretches the data phase with hresp high.
  assign err_first = dp_valid && !hready && hresp;

  // The AP entry is sampled by the slave only if it was actually on the bus
  // as NONSEQ, which is not the case while err_hold forces IDLE.
  assign ap_accept = ap_valid && hready && !err_hold;

  // Refill AP when it is empty or leaving. Loading is blocked on the first
  // error edge so the bus stays IDLE during the second error cycle.
  assign pop = fifo_nonempty && (!ap_valid || ap_accept) && !err_first;

  always_comb begin
    ap_valid_n = ap_valid;
    if (pop) begin
      ap_valid_n = 1'b1;
    end else if (ap_accept) begin
      ap_valid_n = 1'b0;
    end
  end

  assign err_hold_n = err_first || (err_hold && !hready);

  always_ff @(posedge hclk) begin
    if (push) begin
      fifo_write[wr_ptr] <= cmd_write;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_size[wr_ptr]  <= cmd_size;
      fifo_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ap_valid  <= 1'b0;
      ap_write  <= 1'b0;
      ap_addr   <= '0;
      ap_size   <= '0;
      ap_wdata  <= '0;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      err_hold  <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
      hwdata_q  <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // FIFO pointers and occupancy
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase

      // Address phase; fields hold when AP empties so haddr/hwrite/hsize stay put
      if (pop) begin
        ap_write <= fifo_write[rd_ptr];
        ap_addr  <= fifo_addr[rd_ptr];
        ap_size  <= fifo_size[rd_ptr];
        ap_wdata <= fifo_wdata[rd_ptr];
      end
      ap_valid <= ap_valid_n;
      err_hold <= err_hold_n;
      htrans_q <= (ap_valid_n && !err_hold_n) ? HTRANS_NONSEQ : HTRANS_IDLE;

      // Data phase advances only when the slave is ready
      if (hready) begin
        if (err_hold) begin
          dp_valid <= 1'b0;
        end else begin
          dp_valid <= ap_valid;
          dp_write <= ap_write;
          if (ap_valid && ap_write) begin
            hwdata_q <= ap_wdata;
          end
        end
      end

      // Completion of the data-phase transfer
      rsp_valid <= hready && dp_valid;
      if (hready && dp_valid) begin
        rsp_write <= dp_write;
        rsp_err   <= hresp;
        rsp_rdata <= (!dp_write && !hresp) ? hrdata : '0;
      end
    end
  end

  assign htrans = htrans_q;
  assign haddr  = ap_addr;
  assign hwrite = ap_write;
  assign hsize  = ap_size;
  assign hwdata = hwdata_q;

endmodule

// File: tb/tb_minitb_ahb_pipelined_master.sv
// tb/tb_minitb_ahb_pipelined_master.sv - scoreboard bench for the pipelined AHB-Lite master
module tb_minitb_ahb_pipelined_master;

  logic        hclk;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  htrans;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  typedef struct packed {
    logic        w;
    logic        e;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [7:0] dph_addr = 8'h00;

  minitb_ahb_pipelined_master #(
    .addrWidth(8),
    .dataWidth(32),
    .cmdDepth(4)
  ) dut (
    .hclk(hclk),
    .hreset(hreset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_size(cmd_size),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_write(rsp_write),
    .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .htrans(htrans),
    .haddr(haddr),
    .hwrite(hwrite),
    .hsize(hsize),
    .hwdata(hwdata),
    .hrdata(hrdata),
    .hready(hready),
    .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Slave model: read data is the data-phase address plus 0x100
  always @(posedge hclk) begin
    if (hready && htrans == 2'b10) dph_addr <= haddr;
  end
  assign hrdata = 32'(dph_addr) + 32'h100;

  // Scoreboard consumer
  always @(negedge hclk) begin
    if (!hreset && rsp_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL rsp_unexpected got w=%0b e=%0b d=%h want no response", rsp_write, rsp_err, rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({rsp_write, rsp_err, rsp_rdata} !== {e.w, e.e, e.d}) begin
          n_mis++;
          $display("FAIL rsp_data got w=%0b e=%0b d=%h want w=%0b e=%0b d=%h",
                   rsp_write, rsp_err, rsp_rdata, e.w, e.e, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Offer one command at the current negedge and return at the negedge after acceptance.
  task automatic push_cmd(input logic w, input logic [7:0] a, input logic [31:0] d, input logic err);
    int guard;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = 3'b010;
    cmd_wdata = d;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge hclk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_mis++;
      $display("FAIL cmd_accept_timeout got cmd_ready=%0b want 1", cmd_ready);
    end
    e.w = w;
    e.e = err;
    e.d = (w || err) ? 32'h0 : (32'(a) + 32'h100);
    sb.push_back(e);
    @(negedge hclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(negedge hclk);
      guard++;
    end
    @(negedge hclk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL %s_drain got %0d pending want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    hready = 1'b1; hresp = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    n_cmp++;
    if ({htrans, haddr, hwrite, hsize, hwdata} !== 46'h0) begin
      n_mis++;
      $display("FAIL reset_bus got htrans=%0h haddr=%h hwrite=%0b hsize=%0h hwdata=%h want all 0",
               htrans, haddr, hwrite, hsize, hwdata);
    end
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
      n_mis++;
      $display("FAIL reset_rsp got v=%0b e=%0b d=%h want 0", rsp_valid, rsp_err, rsp_rdata);
    end
    hreset = 1'b0;
    @(negedge hclk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready);
    end
  endtask

  task automatic test_single_write();
    push_cmd(1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
    n_cmp++;
    if (htrans !== 2'b00) begin
      n_mis++;
      $display("FAIL wr_latency_c1 got htrans=%0h want 0", htrans);
    end
    @(negedge hclk);
    n_cmp++;
    if ({htrans, haddr, hwrite, hsize} !== {2'b10, 8'h10, 1'b1, 3'b010}) begin
      n_mis++;
      $display("FAIL wr_addr_phase got htrans=%0h haddr=%h hwrite=%0b hsize=%0h want 2 10 1 2",
               htrans, haddr, hwrite, hsize);
    end
    @(negedge hclk);
    n_cmp++;
    if (hwdata !== 32'hDEADBEEF) begin
      n_mis++;
      $display("FAIL wr_data_phase got hwdata=%h want deadbeef", hwdata);
    end
    @(negedge hclk);
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL wr_rsp_timing got rsp_valid=%0b want 1", rsp_valid);
    end
    wait_drain("single_write");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        exp_t e;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'(4 * k); cmd_size = 3'b010; cmd_wdata = '0;
        e.w = 1'b0; e.e = 1'b0; e.d = 32'(4 * k) + 32'h100;
        sb.push_back(e);
      end else begin
        cmd_valid = 1'b0;
      end
      if (k >= 2 && k < 6) begin
        n_cmp++;
        if (htrans !== 2'b10 || haddr !== 8'(4 * (k - 2))) begin
          n_mis++;
          $display("FAIL b2b_nonseq_%0d got htrans=%0h haddr=%h want 2 %h", k, htrans, haddr, 8'(4 * (k - 2)));
        end
      end
      if (k >= 4) begin
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
          n_mis++;
          $display("FAIL b2b_rsp_%0d got rsp_valid=%0b want 1", k, rsp_valid);
        end
      end
      @(negedge hclk);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_wait_states();
    push_cmd(1'b1, 8'h20, 32'hCAFE0020, 1'b0);
    push_cmd(1'b0, 8'h24, 32'h0, 1'b0);
    @(negedge hclk);
    n_cmp++;
    if (htrans !== 2'b10 || haddr !== 8'h24 || hwdata !== 32'hCAFE0020) begin
      n_mis++;
      $display("FAIL ws_overlap got htrans=%0h haddr=%h hwdata=%h want 2 24 cafe0020", htrans, haddr, hwdata);
    end
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      n_cmp++;
      if (htrans !== 2'b10 || haddr !== 8'h24 || hwrite !== 1'b0 || hwdata !== 32'hCAFE0020 || rsp_valid !== 1'b0) begin
        n_mis++;
        $display("FAIL ws_hold_%0d got htrans=%0h haddr=%h hwrite=%0b hwdata=%h rsp_valid=%0b want 2 24 0 cafe0020 0",
                 i, htrans, haddr, hwrite, hwdata, rsp_valid);
      end
    end
    hready = 1'b1;
    wait_drain("wait_states");
  endtask

  task automatic test_fifo_full();
    int guard;
    exp_t e;
    hready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(i[0], 8'h50 + 8'(4 * i), 32'hA5000000 + 32'(i), 1'b0);
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h64; cmd_size = 3'b010; cmd_wdata = 32'hA5000005;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL full_cmd_ready got %0b want 0", cmd_ready);
    end
    @(negedge hclk);
    n_cmp++;
    if (cmd_ready !== 1'b0 || htrans !== 2'b10 || haddr !== 8'h50) begin
      n_mis++;
      $display("FAIL full_hold got cmd_ready=%0b htrans=%0h haddr=%h want 0 2 50", cmd_ready, htrans, haddr);
    end
    e.w = 1'b1; e.e = 1'b0; e.d = 32'h0;
    sb.push_back(e);
    hready = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge hclk);
      guard++;
    end
    n_cmp++;
    if (guard >= 20) begin
      n_mis++;
      $display("FAIL full_release got cmd_ready=%0b want 1", cmd_ready);
    end
    @(negedge hclk);
    cmd_valid = 1'b0;
    wait_drain("fifo_full");
  endtask

  task automatic test_error();
    push_cmd(1'b0, 8'h30, 32'h0, 1'b1);
    push_cmd(1'b1, 8'h34, 32'h00000034, 1'b0);
    @(negedge hclk);
    n_cmp++;
    if (htrans !== 2'b10 || haddr !== 8'h34) begin
      n_mis++;
      $display("FAIL err_setup got htrans=%0h haddr=%h want 2 34", htrans, haddr);
    end
    hready = 1'b0; hresp = 1'b1;
    @(negedge hclk);
    n_cmp++;
    if (htrans !== 2'b00 || haddr !== 8'h34 || hwrite !== 1'b1) begin
      n_mis++;
      $display("FAIL err_idle got htrans=%0h haddr=%h hwrite=%0b want 0 34 1", htrans, haddr, hwrite);
    end
    hready = 1'b1;
    @(negedge hclk);
    hresp = 1'b0;
    n_cmp++;
    if (htrans !== 2'b10 || haddr !== 8'h34) begin
      n_mis++;
      $display("FAIL err_reissue got htrans=%0h haddr=%h want 2 34", htrans, haddr);
    end
    wait_drain("error");
  endtask

  task automatic test_reset_mid();
    push_cmd(1'b0, 8'h40, 32'h0, 1'b0);
    push_cmd(1'b1, 8'h44, 32'h44444444, 1'b0);
    push_cmd(1'b1, 8'h48, 32'h48484848, 1'b0);
    hreset = 1'b1;
    #1;
    n_cmp++;
    if ({htrans, haddr, hwrite, hsize, hwdata, rsp_valid} !== 47'h0) begin
      n_mis++;
      $display("FAIL rst_mid_outputs got htrans=%0h haddr=%h hwrite=%0b hsize=%0h hwdata=%h rsp_valid=%0b want all 0",
               htrans, haddr, hwrite, hsize, hwdata, rsp_valid);
    end
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge hclk);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_mis++;
        $display("FAIL rst_mid_norsp got rsp_valid=%0b want 0", rsp_valid);
      end
    end
    hreset = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL rst_mid_ready got %0b want 1", cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      n_cmp++;
      if (htrans !== 2'b00 || rsp_valid !== 1'b0) begin
        n_mis++;
        $display("FAIL rst_mid_empty got htrans=%0h rsp_valid=%0b want 0 0", htrans, rsp_valid);
      end
    end
    push_cmd(1'b0, 8'h70, 32'h0, 1'b0);
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_states();
    test_fifo_full();
    test_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
